// File: rtl/iob_cache_be_arbiter.sv
// Round-robin arbiter sharing one back-end memory port among N_MASTERS cache back ends.
// Define IOB_CACHE_BE_ARB_FIXED_PRIO_EN to pin the priority pointer at 0 (lowest index always wins).
module iob_cache_be_arbiter #(
    parameter int unsigned N_MASTERS   = 2,
    parameter int unsigned BE_ADDR_W   = 24,
    parameter int unsigned BE_DATA_W   = 32,
    parameter int unsigned BE_NBYTES   = BE_DATA_W / 8,
    parameter int unsigned N_MASTERS_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                           clk_i,
    input  logic                           arst_n_i,
    input  logic                           cke_i,
    input  logic [N_MASTERS-1:0]           req_valid_i,
    input  logic [N_MASTERS*BE_ADDR_W-1:0] req_addr_i,
    input  logic [N_MASTERS*BE_DATA_W-1:0] req_wdata_i,
    input  logic [N_MASTERS*BE_NBYTES-1:0] req_wstrb_i,
    input  logic [N_MASTERS-1:0]           req_lock_i,
    output logic [N_MASTERS-1:0]           req_ready_o,
    output logic [N_MASTERS-1:0]           req_rvalid_o,
    output logic [BE_DATA_W-1:0]           req_rdata_o,
    output logic                           be_valid_o,
    output logic [BE_ADDR_W-1:0]           be_addr_o,
    output logic [BE_DATA_W-1:0]           be_wdata_o,
    output logic [BE_NBYTES-1:0]           be_wstrb_o,
    input  logic                           be_ready_i,
    input  logic [BE_DATA_W-1:0]           be_rdata_i,
    input  logic                           be_rvalid_i,
    output logic [N_MASTERS-1:0]           grant_o,
    output logic                           busy_o
);

    localparam int unsigned SUM_W = N_MASTERS_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT_R = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [N_MASTERS_W-1:0] gnt_q, gnt_d;
    logic [N_MASTERS_W-1:0] ptr_q, ptr_d;

    logic [BE_ADDR_W-1:0] addr_a  [N_MASTERS];
    logic [BE_DATA_W-1:0] wdata_a [N_MASTERS];
    logic [BE_NBYTES-1:0] wstrb_a [N_MASTERS];

    for (genvar k = 0; k < N_MASTERS; k++) begin : g_unpack
        assign addr_a[k]  = req_addr_i[k*BE_ADDR_W +: BE_ADDR_W];
        assign wdata_a[k] = req_wdata_i[k*BE_DATA_W +: BE_DATA_W];
        assign wstrb_a[k] = req_wstrb_i[k*BE_NBYTES +: BE_NBYTES];
    end

    logic                 g_valid, g_lock, g_acc, g_write;
    logic [BE_NBYTES-1:0] g_wstrb;

    assign g_valid     = req_valid_i[gnt_q];
    assign g_lock      = req_lock_i[gnt_q];
    assign g_wstrb     = wstrb_a[gnt_q];
    assign g_write     = |g_wstrb;
    assign g_acc       = g_valid & be_ready_i & cke_i;
    assign req_rdata_o = be_rdata_i;

    // First valid requester at or above the pointer, wrapping modulo N_MASTERS.
    logic                   arb_found;
    logic [N_MASTERS_W-1:0] arb_idx;
    logic [SUM_W-1:0]       arb_sum;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_sum   = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            arb_sum = {1'b0, ptr_q} + SUM_W'(i);
            if (arb_sum >= SUM_W'(N_MASTERS)) begin
                arb_sum = arb_sum - SUM_W'(N_MASTERS);
            end
            if (!arb_found && req_valid_i[arb_sum[N_MASTERS_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_sum[N_MASTERS_W-1:0];
            end
        end
    end

    logic do_rel;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        ptr_d        = ptr_q;
        do_rel       = 1'b0;
        be_valid_o   = 1'b0;
        be_addr_o    = '0;
        be_wdata_o   = '0;
        be_wstrb_o   = '0;
        req_ready_o  = '0;
        req_rvalid_o = '0;
        grant_o      = '0;
        busy_o       = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    gnt_d   = arb_idx;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                grant_o            = N_MASTERS'(1) << gnt_q;
                be_valid_o         = g_valid & cke_i;
                be_addr_o          = addr_a[gnt_q];
                be_wdata_o         = wdata_a[gnt_q];
                be_wstrb_o         = g_wstrb;
                req_ready_o[gnt_q] = g_acc;
                if (g_acc) begin
                    if (!g_write) begin
                        state_d = S_WAIT_R;
                    end else if (!g_lock) begin
                        do_rel = 1'b1;
                    end
                end else if (!g_valid && !g_lock) begin
                    do_rel = 1'b1;
                end
            end
            S_WAIT_R: begin
                grant_o             = N_MASTERS'(1) << gnt_q;
                req_rvalid_o[gnt_q] = be_rvalid_i & cke_i;
                if (be_rvalid_i) begin
                    if (g_lock) begin
                        state_d = S_ACCESS;
                    end else begin
                        do_rel = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Releasing requester k hands priority to k+1.
        if (do_rel) begin
            state_d = S_IDLE;
`ifdef IOB_CACHE_BE_ARB_FIXED_PRIO_EN
            ptr_d   = '0;
`else
            ptr_d   = (gnt_q == N_MASTERS_W'(N_MASTERS - 1)) ? '0 : N_MASTERS_W'(gnt_q + 1'b1);
`endif
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
